// File: rtl/rdata_arb_pkg.sv
// Shared encodings for the 2:1 AXI R-channel burst-locked arbiter.
package rdata_arb_pkg;

  localparam int RESP_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT_S1 = 2'd1,
    ST_GNT_S2 = 2'd2
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_S1   = 2'b01;
  localparam logic [1:0] GNT_S2   = 2'b10;

  function automatic logic [1:0] state_grant(input state_t st);
    case (st)
      ST_GNT_S1: state_grant = GNT_S1;
      ST_GNT_S2: state_grant = GNT_S2;
      default:   state_grant = GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rdata_arb_2to1_r_slice.sv
// Two-entry skid buffer: registered output stage plus one overflow entry.
// in_ready comes only from flops, so no combinational path from out_ready.
module r_slice #(
  parameter int W = 39
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] out_data_r;
  logic         out_valid_r;
  logic [W-1:0] skid_data_r;
  logic         skid_valid_r;

  assign in_ready  = ~skid_valid_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;

  // Output stage refills from skid first, else from the input; skid catches a beat on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_r   <= '0;
      out_valid_r  <= 1'b0;
      skid_data_r  <= '0;
      skid_valid_r <= 1'b0;
    end else if (!out_valid_r || out_ready) begin
      if (skid_valid_r) begin
        out_data_r   <= skid_data_r;
        out_valid_r  <= 1'b1;
        skid_valid_r <= 1'b0;
      end else begin
        out_data_r  <= in_valid ? in_data : '0;
        out_valid_r <= in_valid;
      end
    end else if (in_valid && !skid_valid_r) begin
      skid_data_r  <= in_data;
      skid_valid_r <= 1'b1;
    end else begin
      skid_valid_r <= skid_valid_r;
    end
  end

endmodule

// File: rtl/rdata_arb_2to1.sv
// Burst-locked round-robin arbiter sharing one AXI R master port between two slaves.
// Optional RDATA_ARB_SLICE_EN inserts a skid-buffer slice in front of the master port.
module rdata_arb_2to1
  import rdata_arb_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              areset,
  output logic [ID_W-1:0]   rid_m,
  output logic [DATA_W-1:0] rdata_m,
  output logic              rlast_m,
  output logic [1:0]        rresp_m,
  output logic              rvalid_m,
  input  logic              rready_m,
  input  logic [ID_W-1:0]   rid_s1,
  input  logic [DATA_W-1:0] rdata_s1,
  input  logic              rlast_s1,
  input  logic [1:0]        rresp_s1,
  input  logic              rvalid_s1,
  output logic              rready_s1,
  input  logic [ID_W-1:0]   rid_s2,
  input  logic [DATA_W-1:0] rdata_s2,
  input  logic              rlast_s2,
  input  logic [1:0]        rresp_s2,
  input  logic              rvalid_s2,
  output logic              rready_s2,
  output logic [1:0]        grant,
  output logic              busy
);

  state_t      state_r;
  state_t      next_state_s;
  logic [1:0]  grant_r;
  logic        busy_r;
  logic [1:0]  last_grant_r;
  logic [1:0]  next_last_s;

  logic [ID_W-1:0]   mux_id_s;
  logic [DATA_W-1:0] mux_data_s;
  logic [RESP_W-1:0] mux_resp_s;
  logic              mux_last_s;
  logic              mux_valid_s;
  logic              sel_ready_s;
  logic              end_s1_s;
  logic              end_s2_s;

  assign grant     = grant_r;
  assign busy      = busy_r;
  assign rready_s1 = grant_r[0] & sel_ready_s;
  assign rready_s2 = grant_r[1] & sel_ready_s;

  // Burst end is the slave-side handshake of the rlast beat.
  assign end_s1_s = rvalid_s1 & rready_s1 & rlast_s1;
  assign end_s2_s = rvalid_s2 & rready_s2 & rlast_s2;

  // Route the owning slave's R fields; drive zeros when nobody owns the port.
  always_comb begin
    mux_id_s    = '0;
    mux_data_s  = '0;
    mux_resp_s  = '0;
    mux_last_s  = 1'b0;
    mux_valid_s = 1'b0;
    if (grant_r == GNT_S1) begin
      mux_id_s    = rid_s1;
      mux_data_s  = rdata_s1;
      mux_resp_s  = rresp_s1;
      mux_last_s  = rlast_s1;
      mux_valid_s = rvalid_s1;
    end else if (grant_r == GNT_S2) begin
      mux_id_s    = rid_s2;
      mux_data_s  = rdata_s2;
      mux_resp_s  = rresp_s2;
      mux_last_s  = rlast_s2;
      mux_valid_s = rvalid_s2;
    end else begin
      mux_valid_s = 1'b0;
    end
  end

  // Next owner: round-robin on ties in IDLE, hand over without a bubble at burst end.
  always_comb begin
    next_state_s = state_r;
    next_last_s  = last_grant_r;
    case (state_r)
      ST_IDLE: begin
        if (rvalid_s1 && (!rvalid_s2 || last_grant_r == GNT_S2)) begin
          next_state_s = ST_GNT_S1;
        end else if (rvalid_s2) begin
          next_state_s = ST_GNT_S2;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_GNT_S1: begin
        if (end_s1_s) begin
          next_last_s  = GNT_S1;
          next_state_s = rvalid_s2 ? ST_GNT_S2 : ST_IDLE;
        end else begin
          next_state_s = ST_GNT_S1;
        end
      end
      ST_GNT_S2: begin
        if (end_s2_s) begin
          next_last_s  = GNT_S2;
          next_state_s = rvalid_s1 ? ST_GNT_S1 : ST_IDLE;
        end else begin
          next_state_s = ST_GNT_S2;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Arbitration state with grant and busy registered alongside it.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r      <= ST_IDLE;
      grant_r      <= GNT_NONE;
      busy_r       <= 1'b0;
      last_grant_r <= GNT_S2;
    end else begin
      state_r      <= next_state_s;
      grant_r      <= state_grant(next_state_s);
      busy_r       <= (next_state_s != ST_IDLE);
      last_grant_r <= next_last_s;
    end
  end

`ifdef RDATA_ARB_SLICE_EN
  localparam int SW = ID_W + DATA_W + RESP_W + 1;

  logic [SW-1:0] slice_in_s;
  logic [SW-1:0] slice_out_s;
  logic          slice_ready_s;
  logic          slice_valid_s;

  assign slice_in_s  = {mux_id_s, mux_data_s, mux_resp_s, mux_last_s};
  assign sel_ready_s = slice_ready_s;

  r_slice #(
    .W (SW)
  ) u_slice (
    .clk       (aclk),
    .rst       (areset),
    .in_data   (slice_in_s),
    .in_valid  (mux_valid_s),
    .in_ready  (slice_ready_s),
    .out_data  (slice_out_s),
    .out_valid (slice_valid_s),
    .out_ready (rready_m)
  );

  assign {rid_m, rdata_m, rresp_m, rlast_m} = slice_out_s;
  assign rvalid_m = slice_valid_s;
`else
  assign sel_ready_s = rready_m;
  assign rid_m       = mux_id_s;
  assign rdata_m     = mux_data_s;
  assign rresp_m     = mux_resp_s;
  assign rlast_m     = mux_last_s;
  assign rvalid_m    = mux_valid_s;
`endif

endmodule

// File: tb/tb_rdata_arb_2to1.sv
// Directed self-checking bench for rdata_arb_2to1 (slice variant under RDATA_ARB_SLICE_EN).
module tb_rdata_arb_2to1;

  logic        aclk;
  logic        areset;
  logic [3:0]  rid_m;
  logic [31:0] rdata_m;
  logic        rlast_m;
  logic [1:0]  rresp_m;
  logic        rvalid_m;
  logic        rready_m;
  logic [3:0]  rid_s1;
  logic [31:0] rdata_s1;
  logic        rlast_s1;
  logic [1:0]  rresp_s1;
  logic        rvalid_s1;
  logic        rready_s1;
  logic [3:0]  rid_s2;
  logic [31:0] rdata_s2;
  logic        rlast_s2;
  logic [1:0]  rresp_s2;
  logic        rvalid_s2;
  logic        rready_s2;
  logic [1:0]  grant;
  logic        busy;

  int total = 0;
  int bad   = 0;

  rdata_arb_2to1 #(.ID_W(4), .DATA_W(32)) dut (
    .aclk(aclk), .areset(areset),
    .rid_m(rid_m), .rdata_m(rdata_m), .rlast_m(rlast_m), .rresp_m(rresp_m),
    .rvalid_m(rvalid_m), .rready_m(rready_m),
    .rid_s1(rid_s1), .rdata_s1(rdata_s1), .rlast_s1(rlast_s1), .rresp_s1(rresp_s1),
    .rvalid_s1(rvalid_s1), .rready_s1(rready_s1),
    .rid_s2(rid_s2), .rdata_s2(rdata_s2), .rlast_s2(rlast_s2), .rresp_s2(rresp_s2),
    .rvalid_s2(rvalid_s2), .rready_s2(rready_s2),
    .grant(grant), .busy(busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic mid();
    @(negedge aclk);
  endtask

  task automatic drive_s1(input logic v, input logic [3:0] id, input logic [31:0] d, input logic l);
    rvalid_s1 = v; rid_s1 = id; rdata_s1 = d; rlast_s1 = l; rresp_s1 = 2'b00;
  endtask

  task automatic drive_s2(input logic v, input logic [3:0] id, input logic [31:0] d, input logic l);
    rvalid_s2 = v; rid_s2 = id; rdata_s2 = d; rlast_s2 = l; rresp_s2 = 2'b10;
  endtask

  task automatic pulse_reset();
    areset = 1'b1;
    #2;
    areset = 1'b0;
    tick();
  endtask

  task automatic see(input string tag, input logic [1:0] g, input logic [31:0] d, input logic [3:0] id,
                     input logic l);
    check_eq({tag, "_grant"}, 64'(grant), 64'(g));
    check_eq({tag, "_rvalid"}, 64'(rvalid_m), 64'(1'b1));
    check_eq({tag, "_rdata"}, 64'(rdata_m), 64'(d));
    check_eq({tag, "_rid"}, 64'(rid_m), 64'(id));
    check_eq({tag, "_rlast"}, 64'(rlast_m), 64'(l));
  endtask

`ifdef RDATA_ARB_SLICE_EN
  int   idx;
  int   nout;
  int   first_cyc;
  int   gaps;
  logic acc_in;
`endif

  initial begin
    areset = 1'b1;
    rready_m = 1'b0;
    drive_s1(1'b0, 4'h0, 32'h0, 1'b0);
    drive_s2(1'b0, 4'h0, 32'h0, 1'b0);
    #7;
    check_eq("rst_grant", 64'(grant), 64'(2'b00));
    check_eq("rst_busy", 64'(busy), 64'(1'b0));
    check_eq("rst_rvalid", 64'(rvalid_m), 64'(1'b0));
    check_eq("rst_rready_s1", 64'(rready_s1), 64'(1'b0));
    check_eq("rst_rready_s2", 64'(rready_s2), 64'(1'b0));
    #5;
    areset = 1'b0;
    tick();

`ifndef RDATA_ARB_SLICE_EN
    // s1 alone: 4-beat burst, id 3, data A0..A3
    drive_s1(1'b1, 4'h3, 32'hA0, 1'b0);
    rready_m = 1'b1;
    mid();
    check_eq("t1_idle_rvalid", 64'(rvalid_m), 64'(1'b0));
    check_eq("t1_idle_rready_s1", 64'(rready_s1), 64'(1'b0));
    tick();
    for (int i = 0; i < 4; i++) begin
      drive_s1(1'b1, 4'h3, 32'hA0 + 32'(i), (i == 3));
      mid();
      see("t1_beat", 2'b01, 32'hA0 + 32'(i), 4'h3, (i == 3));
      check_eq("t1_busy", 64'(busy), 64'(1'b1));
      tick();
    end
    drive_s1(1'b0, 4'h0, 32'h0, 1'b0);
    mid();
    check_eq("t1_end_grant", 64'(grant), 64'(2'b00));
    check_eq("t1_end_rdata", 64'(rdata_m), 64'(32'h0));

    // tie after reset: s1 first, s2 follows with no bubble
    pulse_reset();
    drive_s1(1'b1, 4'h1, 32'hB0, 1'b0);
    drive_s2(1'b1, 4'h2, 32'hC0, 1'b0);
    mid();
    check_eq("t2_idle_grant", 64'(grant), 64'(2'b00));
    tick();
    mid();
    see("t2_s1b0", 2'b01, 32'hB0, 4'h1, 1'b0);
    check_eq("t2_rready_s2", 64'(rready_s2), 64'(1'b0));
    tick();
    drive_s1(1'b1, 4'h1, 32'hB1, 1'b1);
    mid();
    see("t2_s1b1", 2'b01, 32'hB1, 4'h1, 1'b1);
    tick();
    drive_s1(1'b0, 4'h0, 32'h0, 1'b0);
    mid();
    see("t2_s2b0", 2'b10, 32'hC0, 4'h2, 1'b0);
    check_eq("t2_s2_rresp", 64'(rresp_m), 64'(2'b10));
    check_eq("t2_s2_rready", 64'(rready_s2), 64'(1'b1));
    tick();
    drive_s2(1'b1, 4'h2, 32'hC1, 1'b1);
    mid();
    see("t2_s2b1", 2'b10, 32'hC1, 4'h2, 1'b1);
    tick();
    drive_s2(1'b0, 4'h0, 32'h0, 1'b0);
    // single s1 beat leaves s1 as last owner, so s2 wins the next tie
    drive_s1(1'b1, 4'h4, 32'hD0, 1'b1);
    tick();
    mid();
    see("t2_s1single", 2'b01, 32'hD0, 4'h4, 1'b1);
    tick();
    drive_s1(1'b1, 4'h1, 32'hE0, 1'b1);
    drive_s2(1'b1, 4'h2, 32'hF0, 1'b1);
    mid();
    check_eq("t2b_idle_grant", 64'(grant), 64'(2'b00));
    tick();
    mid();
    see("t2b_s2_wins", 2'b10, 32'hF0, 4'h2, 1'b1);
    tick();
    drive_s2(1'b0, 4'h0, 32'h0, 1'b0);
    mid();
    see("t2b_s1_next", 2'b01, 32'hE0, 4'h1, 1'b1);
    tick();
    drive_s1(1'b0, 4'h0, 32'h0, 1'b0);

    // s2 arrives mid s1 burst and must wait for s1's rlast
    drive_s1(1'b1, 4'h7, 32'h10, 1'b0);
    tick();
    mid();
    see("t3_g0", 2'b01, 32'h10, 4'h7, 1'b0);
    tick();
    drive_s2(1'b1, 4'h9, 32'h55, 1'b1);
    for (int i = 1; i < 4; i++) begin
      drive_s1(1'b1, 4'h7, 32'h10 + 32'(i), (i == 3));
      mid();
      see("t3_s1", 2'b01, 32'h10 + 32'(i), 4'h7, (i == 3));
      check_eq("t3_rready_s2", 64'(rready_s2), 64'(1'b0));
      tick();
    end
    drive_s1(1'b0, 4'h0, 32'h0, 1'b0);
    mid();
    see("t3_s2", 2'b10, 32'h55, 4'h9, 1'b1);
    tick();
    drive_s2(1'b0, 4'h0, 32'h0, 1'b0);

    // rready_m stalls during an s2 burst: 1,0,0,1,1
    drive_s2(1'b1, 4'h5, 32'h30, 1'b0);
    tick();
    mid();
    see("t4_j0", 2'b10, 32'h30, 4'h5, 1'b0);
    tick();
    drive_s2(1'b1, 4'h5, 32'h31, 1'b0);
    rready_m = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mid();
      see("t4_stall", 2'b10, 32'h31, 4'h5, 1'b0);
      check_eq("t4_stall_rready_s2", 64'(rready_s2), 64'(1'b0));
      tick();
    end
    rready_m = 1'b1;
    mid();
    see("t4_j1", 2'b10, 32'h31, 4'h5, 1'b0);
    tick();
    drive_s2(1'b1, 4'h5, 32'h32, 1'b1);
    mid();
    see("t4_j2", 2'b10, 32'h32, 4'h5, 1'b1);
    tick();
    drive_s2(1'b0, 4'h0, 32'h0, 1'b0);
    mid();
    check_eq("t4_end_grant", 64'(grant), 64'(2'b00));
    tick();

    // asynchronous reset mid-burst
    drive_s1(1'b1, 4'h8, 32'h70, 1'b0);
    tick();
    mid();
    see("t5_pre", 2'b01, 32'h70, 4'h8, 1'b0);
    #2;
    areset = 1'b1;
    #1;
    check_eq("t5_rst_grant", 64'(grant), 64'(2'b00));
    check_eq("t5_rst_busy", 64'(busy), 64'(1'b0));
    check_eq("t5_rst_rvalid", 64'(rvalid_m), 64'(1'b0));
    check_eq("t5_rst_rdata", 64'(rdata_m), 64'(32'h0));
    check_eq("t5_rst_rready_s1", 64'(rready_s1), 64'(1'b0));
    mid();
    areset = 1'b0;
    drive_s1(1'b1, 4'h1, 32'h80, 1'b1);
    drive_s2(1'b1, 4'h2, 32'h90, 1'b1);
    tick();
    mid();
    see("t5_s1_first", 2'b01, 32'h80, 4'h1, 1'b1);
    tick();
    drive_s1(1'b0, 4'h0, 32'h0, 1'b0);
    mid();
    see("t5_s2_next", 2'b10, 32'h90, 4'h2, 1'b1);
    tick();
    drive_s2(1'b0, 4'h0, 32'h0, 1'b0);
`else
    // s1 streams 8 beats, master stalls for 3 cycles
    idx = 0;
    nout = 0;
    first_cyc = -1;
    gaps = 0;
    for (int c = 0; c < 30; c++) begin
      drive_s1((idx < 8), 4'h6, 32'h100 + 32'(idx), (idx == 7));
      rready_m = !(c >= 4 && c <= 6);
      mid();
      acc_in = rvalid_s1 & rready_s1;
      if (rvalid_m && first_cyc < 0) first_cyc = c;
      if (rready_m && first_cyc >= 0 && nout < 8 && !rvalid_m) gaps++;
      if (rvalid_m && rready_m) begin
        check_eq("sl_beat_data", 64'(rdata_m), 64'(32'h100 + 32'(nout)));
        check_eq("sl_beat_last", 64'(rlast_m), 64'(nout == 7));
        nout++;
      end
      tick();
      if (acc_in) idx++;
    end
    check_eq("sl_first_latency", 64'(first_cyc), 64'(2));
    check_eq("sl_beats_out", 64'(nout), 64'(8));
    check_eq("sl_beats_in", 64'(idx), 64'(8));
    check_eq("sl_gaps", 64'(gaps), 64'(0));
    mid();
    check_eq("sl_end_grant", 64'(grant), 64'(2'b00));
    check_eq("sl_end_rvalid", 64'(rvalid_m), 64'(1'b0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rdata_arb_2to1.md
Name: rdata_arb_2to1

Overview:
- Burst-locked round-robin arbiter for the AXI read-data (R) channel: two slaves share one master port.
- Grant is registered and held from first beat until the RLAST handshake, so beats of different bursts never interleave.
- Sits in router_slave in place of the unconditional priority mux, so a continuously valid slave 1 cannot starve slave 2.

Parameters:
- ID_W, 4, RID width
- DATA_W, 32, RDATA width

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous reset, active-high
- rid_m  out  ID_W  master RID
- rdata_m  out  DATA_W  master RDATA
- rlast_m  out  1  master RLAST
- rresp_m  out  2  master RRESP
- rvalid_m  out  1  master RVALID
- rready_m  in  1  master RREADY
- rid_s1, rdata_s1, rlast_s1, rresp_s1, rvalid_s1  in  ID_W/DATA_W/1/2/1  slave 1 R channel
- rready_s1  out  1  slave 1 RREADY
- rid_s2, rdata_s2, rlast_s2, rresp_s2, rvalid_s2  in  ID_W/DATA_W/1/2/1  slave 2 R channel
- rready_s2  out  1  slave 2 RREADY
- grant  out  2  one-hot current owner: 01 = s1, 10 = s2, 00 = idle
- busy  out  1  grant != 00

Behaviour:
- Clock and reset: single clock aclk; areset is asynchronous, active-high.
- Reset values:
  - state = IDLE, grant = 00, last_grant = s2 (so s1 wins the first tie).
  - All master outputs are 0; rready_s1 = rready_s2 = 0.
- FSM states: IDLE, GNT_S1, GNT_S2.
- IDLE:
  - Only s1 valid: go to GNT_S1 next cycle. Only s2 valid: go to GNT_S2.
  - Both valid: grant the slave that is not last_grant.
  - Neither valid: stay in IDLE.
  - First-burst latency is 1 cycle from rvalid_sx to rvalid_m.
- GNT_Sx:
  - Datapath is combinational: m outputs = sx inputs; rready_sx = rready_m; the other slave's rready = 0.
  - A beat transfers when rvalid_sx & rready_m.
- End of burst, on a beat with rlast_sx = 1:
  - last_grant <= sx.
  - Other slave valid in the same cycle: move directly to its GNT state, with no bubble.
  - Otherwise: move to IDLE.
- Non-last beats and stalls (rready_m = 0) hold the grant. rvalid_sx low mid-burst holds the grant; the arbiter does not re-arbitrate on gaps.
- In IDLE: rvalid_m = 0, rlast_m = 0, rid/rdata/rresp driven 0.
- Ungranted slave's rvalid is ignored; the slave must hold it per AXI.
- Reset mid-burst: immediately returns to IDLE with outputs zero. Partial-burst recovery is the system's responsibility.
- No arithmetic; no counters beyond the FSM.

Optional Feature:
- Macro: RDATA_ARB_SLICE_EN.
- Defined:
  - A 2-entry skid-buffer register slice sits between the mux and the master port.
  - All m outputs are registered, +1 cycle latency; full throughput (1 beat/cycle) is sustained.
  - rready_sx = grant_x & slice_not_full, with no combinational path from rready_m.
  - Burst-end is detected on the slave-side handshake, so back-to-back grant switching is preserved.
  - Slice reset state is empty.
- Not defined: behaviour is exactly as above, purely combinational datapath.

Decomposition:
- Package rdata_arb_pkg:
  - State encoding constants (IDLE = 2'd0, GNT_S1 = 2'd1, GNT_S2 = 2'd2).
  - Grant encodings GNT_NONE/GNT_S1/GNT_S2.
  - RESP_W = 2.
- One natural sub-module, r_slice: the skid buffer of width ID_W+DATA_W+3, instantiated only under RDATA_ARB_SLICE_EN.

Test Plan:
- Reset, then s1 presents a 4-beat burst (rid = 3, data 0xA0..0xA3), rready_m = 1 → grant = 01 from cycle 1; 4 beats out in 4 consecutive cycles; grant = 00 after rlast.
- Both rvalid rise together with 2-beat bursts → s1 is served first, then s2 with zero idle cycles between rlast of s1 and the first beat of s2. Repeat: s2 wins the next tie.
- s1 mid-burst (beat 2 of 4), s2 asserts rvalid → rready_s2 stays 0 and rdata_m never shows s2 data until s1's rlast handshake.
- rready_m toggles 1,0,0,1 during an s2 burst → rdata_m/rid_m stay stable while stalled; beat count is preserved; grant held.
- areset pulsed asynchronously mid-burst → same-cycle outputs all 0 and grant = 00; after release, s1 wins the first tie.
- With RDATA_ARB_SLICE_EN: s1 streams 8 beats while rready_m is held low for 3 cycles → no beat lost or duplicated; throughput is 1 beat/cycle when rready_m = 1; first beat latency is 2 cycles.
